output_module: RTL and testbench
================================

# output_module

Output-side counterpart of the router's input module: one instance per router output port. It arbitrates among the input modules that target this port, locks the port to the winning input for a whole wormhole packet (head through tail), and drives the flit onto the outbound link through a single registered stage with valid/ready flow control. Sits between the input modules' routed `fout_req_o` streams and the router's external output link.

## Interface
- `NumInputs`, default 4: number of requesting input modules, ≥2.
- `clk`  in  1: single clock, all state on rising edge.
- `arst`  in  1: asynchronous reset, active-high; clears all state immediately.
- `fin_req_i`  in  `s_flit_req_t [NumInputs]`: per-input request; uses `.valid`, `.fdata`; flit type is the `flit_type_t` field of `.fdata` (HEAD_FLIT, BODY_FLIT, TAIL_FLIT, HEAD_TAIL_FLIT).
- `fin_resp_o`  out  `s_flit_resp_t [NumInputs]`: per-input `.ready`.
- `fout_req_o`  out  `s_flit_req_t`: outbound flit, registered.
- `fout_resp_i`  in  `s_flit_resp_t`: outbound `.ready` from downstream.

## Operation
- Transfer on any channel = valid && ready in the same cycle.
- FSM states: IDLE (port free), LOCKED (owned by `lock_idx`).
- Output register: `out_valid`, `out_flit`. `can_load = !out_valid || fout_resp_i.ready`.
- IDLE:
  - Candidates: inputs with valid and type HEAD_FLIT or HEAD_TAIL_FLIT. Valid BODY/TAIL flits from any input in IDLE are protocol errors: never granted, ready held 0.
  - Round-robin among candidates starting at `rr_ptr`; winner `w` chosen combinationally.
  - `fin_resp_o[w].ready = can_load`; all others 0.
  - On transfer of HEAD_FLIT: load flit, `lock_idx <= w`, go LOCKED.
  - On transfer of HEAD_TAIL_FLIT: load flit, stay IDLE.
  - Either transfer: `rr_ptr <= (w+1) mod NumInputs`.
- LOCKED:
  - Only `fin_resp_o[lock_idx].ready = can_load`; all others 0 regardless of their flits.
  - Any flit type from `lock_idx` is forwarded unchanged; no type checking inside the packet.
  - On transfer of TAIL_FLIT: go IDLE. `rr_ptr` not updated in LOCKED.
- Output: `fout_req_o.valid = out_valid`, `.fdata = out_flit`. Loading when `can_load` and a transfer occurs; `out_valid <= 0` when downstream takes the flit and nothing is loaded. `out_flit` held stable while `out_valid && !fout_resp_i.ready`.
- Ready outputs must not depend on any `fin_req_i[*].valid` other than via arbitration in IDLE; no combinational path from `fin_req_i` to `fout_req_o`.

## Timing
- Reset values: `fout_req_o.valid=0`, `fout_req_o.fdata=0`, all `fin_resp_o[*].ready=0` while `arst` high; state IDLE, `rr_ptr=0`, `lock_idx=0`.
- Latency: flit accepted at cycle t is on `fout_req_o` at t+1.
- Throughput: one flit/cycle with downstream ready held 1; no bubble between packets (tail accepted at t, next head may be accepted at t+1).
- Backpressure: `fout_resp_i.ready=0` with `out_valid=1` → all `fin_resp_o[*].ready=0` same cycle (combinational ready path).
- Simultaneous tail accept and downstream pop: both happen; register reloaded.
- Reset mid-packet: lock dropped, in-flight output flit discarded; after deassert, next transfer requires a head.
- `rr_ptr` wraps `NumInputs-1 → 0`.

## Test plan
- Single HEAD_TAIL from input 2, downstream ready=1 → ready[2]=1 at cycle t, `fout_req_o` valid with identical fdata at t+1, state stays IDLE, `rr_ptr`=3.
- Inputs 0 and 1 both present HEAD_TAIL continuously after reset → grants alternate 0,1,0,1; one flit out per cycle.
- Input 1 sends HEAD, BODY, BODY, TAIL while input 3 holds a HEAD valid → input 3 ready stays 0 for 4 cycles; input 3 granted the cycle after TAIL is accepted; output order is 4 flits of input 1 then input 3's head.
- Downstream ready=0 for 5 cycles mid-packet → `fout_req_o` fdata stable, all input readies 0; resumes with no flit lost or duplicated.
- Input 0 presents BODY_FLIT in IDLE with no other request → ready[0]=0 indefinitely, `fout_req_o.valid` stays 0.
- `arst` pulsed after HEAD accepted from input 2 → outputs go to reset values immediately; afterward input 2 BODY is refused, a HEAD from input 0 is granted.

Source files
------------

// File: rtl/output_module.sv
// Router output port: wormhole arbitration across input modules with a single
// registered outbound stage under valid/ready flow control.

package router_pkg;

  typedef enum logic [1:0] {
    HEAD_FLIT      = 2'd0,
    BODY_FLIT      = 2'd1,
    TAIL_FLIT      = 2'd2,
    HEAD_TAIL_FLIT = 2'd3
  } flit_type_t;

  typedef struct packed {
    flit_type_t  ftype;
    logic [31:0] payload;
  } flit_t;

  typedef struct packed {
    logic  valid;
    flit_t fdata;
  } s_flit_req_t;

  typedef struct packed {
    logic ready;
  } s_flit_resp_t;

endpackage

module output_module
  import router_pkg::*;
#(
  parameter int NumInputs = 4
) (
  input  logic         clk,
  input  logic         arst,
  input  s_flit_req_t  fin_req_i  [NumInputs],
  output s_flit_resp_t fin_resp_o [NumInputs],
  output s_flit_req_t  fout_req_o,
  input  s_flit_resp_t fout_resp_i
);

  localparam int IdxW = $clog2(NumInputs);

  typedef logic [IdxW-1:0] idx_t;
  typedef logic [IdxW:0]   ptr_ext_t;

  typedef enum logic {
    IDLE,
    LOCKED
  } state_t;

  state_t state_q, state_d;
  idx_t   rr_ptr_q, rr_ptr_d;
  idx_t   lock_idx_q, lock_idx_d;
  logic   out_valid_q, out_valid_d;
  flit_t  out_flit_q, out_flit_d;

  logic [NumInputs-1:0] cand;
  logic     win_found;
  idx_t     win_idx;
  ptr_ext_t scan;
  idx_t     sel_idx;
  logic     sel_ok;
  logic     can_load;
  logic     grant_ready;
  logic     xfer;
  flit_t    sel_flit;

  // Only head-bearing flits may open a packet; stray BODY/TAIL in IDLE are ignored.
  always_comb begin
    cand = '0;
    for (int i = 0; i < NumInputs; i++) begin
      cand[i] = fin_req_i[i].valid &&
                (fin_req_i[i].fdata.ftype == HEAD_FLIT ||
                 fin_req_i[i].fdata.ftype == HEAD_TAIL_FLIT);
    end
  end

  // NOTE: every signal driven in an always_comb gets a default before any branch,
  // otherwise a path that skips the assignment infers a latch.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan      = '0;
    for (int off = 0; off < NumInputs; off++) begin
      scan = {1'b0, rr_ptr_q} + ptr_ext_t'(off);
      if (scan >= ptr_ext_t'(NumInputs)) begin
        scan = scan - ptr_ext_t'(NumInputs);
      end
      if (!win_found && cand[scan[IdxW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = scan[IdxW-1:0];
      end
    end
  end

  assign can_load = !out_valid_q || fout_resp_i.ready;
  assign sel_idx  = (state_q == LOCKED) ? lock_idx_q : win_idx;
  assign sel_ok   = (state_q == LOCKED) ? 1'b1 : win_found;
  // Gated by arst so no input sees ready while reset is held.
  assign grant_ready = can_load && sel_ok && !arst;
  assign sel_flit    = fin_req_i[sel_idx].fdata;
  assign xfer        = grant_ready && fin_req_i[sel_idx].valid;

  always_comb begin
    for (int i = 0; i < NumInputs; i++) begin
      fin_resp_o[i]       = '0;
      fin_resp_o[i].ready = grant_ready && (idx_t'(i) == sel_idx);
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    lock_idx_d = lock_idx_q;
    case (state_q)
      IDLE: begin
        if (xfer) begin
          rr_ptr_d = (win_idx == idx_t'(NumInputs - 1)) ? '0 : win_idx + idx_t'(1);
          if (sel_flit.ftype == HEAD_FLIT) begin
            state_d    = LOCKED;
            lock_idx_d = win_idx;
          end
        end
      end
      LOCKED: begin
        if (xfer && sel_flit.ftype == TAIL_FLIT) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A load and a downstream pop in the same cycle simply replace the register.
  always_comb begin
    out_valid_d = out_valid_q;
    out_flit_d  = out_flit_q;
    if (xfer) begin
      out_valid_d = 1'b1;
      out_flit_d  = sel_flit;
    end else if (fout_resp_i.ready) begin
      out_valid_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of its neighbours.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      lock_idx_q  <= '0;
      out_valid_q <= 1'b0;
      out_flit_q  <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      lock_idx_q  <= lock_idx_d;
      out_valid_q <= out_valid_d;
      out_flit_q  <= out_flit_d;
    end
  end

  assign fout_req_o.valid = out_valid_q;
  assign fout_req_o.fdata = out_flit_q;

endmodule

// File: tb/tb_output_module.sv
// Self-checking bench for output_module: directed vector table, hand-written
// reset/protocol sequences, and randomized traffic against a queue-based model.

module tb_output_module;
  import router_pkg::*;

  localparam int N = 4;
  localparam int NumRows = 23;

  logic         clk = 1'b0;
  logic         arst;
  s_flit_req_t  fin_req  [N];
  s_flit_resp_t fin_resp [N];
  s_flit_req_t  fout_req;
  s_flit_resp_t fout_resp;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  output_module #(.NumInputs(N)) dut (
    .clk        (clk),
    .arst       (arst),
    .fin_req_i  (fin_req),
    .fin_resp_o (fin_resp),
    .fout_req_o (fout_req),
    .fout_resp_i(fout_resp)
  );

  typedef struct {
    logic [N-1:0] vld;
    flit_type_t   typ [N];
    logic         ds;
    logic [N-1:0] rdy;
    logic         ov;
    int           orow;
    int           osrc;
  } vec_t;

  vec_t tbl [NumRows];

  // Reference model: accepted flits in order, current packet owner, rr pointer.
  flit_t m_q[$];
  int    m_owner;
  int    m_rr;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] dut_ready();
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) r[i] = fin_resp[i].ready;
    return r;
  endfunction

  function automatic logic [31:0] pl(input int row, input int src);
    return 32'hA000_0000 | (32'(row) << 8) | 32'(src);
  endfunction

  function automatic vec_t mk(input logic [N-1:0] vld, input flit_type_t t0, input flit_type_t t1,
                              input flit_type_t t2, input flit_type_t t3, input logic ds,
                              input logic [N-1:0] rdy, input logic ov, input int orow,
                              input int osrc);
    vec_t v;
    v.vld = vld;
    v.typ[0] = t0; v.typ[1] = t1; v.typ[2] = t2; v.typ[3] = t3;
    v.ds = ds; v.rdy = rdy; v.ov = ov; v.orow = orow; v.osrc = osrc;
    return v;
  endfunction

  task automatic clear_inputs();
    for (int i = 0; i < N; i++) fin_req[i] = '0;
  endtask

  task automatic set_in(input int i, input logic v, input flit_type_t t, input logic [31:0] p);
    fin_req[i].valid         = v;
    fin_req[i].fdata.ftype   = t;
    fin_req[i].fdata.payload = p;
  endtask

  task automatic model_reset();
    m_q.delete();
    m_owner = -1;
    m_rr    = 0;
  endtask

  function automatic logic [N-1:0] m_ready();
    logic [N-1:0] r = '0;
    if (m_q.size() != 0 && !fout_resp.ready) return r;
    if (m_owner >= 0) begin
      r[m_owner] = 1'b1;
      return r;
    end
    for (int k = 0; k < N; k++) begin
      int i = (m_rr + k) % N;
      if (fin_req[i].valid && (fin_req[i].fdata.ftype == HEAD_FLIT ||
                               fin_req[i].fdata.ftype == HEAD_TAIL_FLIT)) begin
        r[i] = 1'b1;
        return r;
      end
    end
    return r;
  endfunction

  task automatic m_commit(input logic [N-1:0] r);
    if (m_q.size() != 0 && fout_resp.ready) void'(m_q.pop_front());
    for (int i = 0; i < N; i++) begin
      if (r[i] && fin_req[i].valid) begin
        m_q.push_back(fin_req[i].fdata);
        if (m_owner < 0) begin
          m_rr = (i + 1) % N;
          if (fin_req[i].fdata.ftype == HEAD_FLIT) m_owner = i;
        end else if (fin_req[i].fdata.ftype == TAIL_FLIT) begin
          m_owner = -1;
        end
      end
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    arst = 1'b1;
    set_in(1, 1'b1, HEAD_FLIT, 32'h1234_5678);
    fout_resp.ready = 1'b1;
    #1;
    check("rst_ready", 64'(dut_ready()), 64'(0));
    check("rst_valid", 64'(fout_req.valid), 64'(0));
    check("rst_fdata", 64'(fout_req.fdata), 64'(0));
    @(posedge clk);
    #1;
    arst = 1'b0;
    clear_inputs();
    model_reset();
  endtask

  initial begin
    flit_t ef;
    logic [N-1:0] r;

    arst = 1'b1;
    clear_inputs();
    fout_resp.ready = 1'b0;
    model_reset();

    // Rows: input, downstream ready, expected readies, expected output register.
    // Output flit of row k is the flit accepted in row orow from input osrc.
    tbl[0]  = mk(4'b0100, HEAD_TAIL_FLIT, HEAD_TAIL_FLIT, HEAD_TAIL_FLIT, HEAD_TAIL_FLIT, 1'b1, 4'b0100, 1'b0, 0, 0);
    tbl[1]  = mk(4'b0011, HEAD_TAIL_FLIT, HEAD_TAIL_FLIT, HEAD_TAIL_FLIT, HEAD_TAIL_FLIT, 1'b1, 4'b0001, 1'b1, 0, 2);
    tbl[2]  = mk(4'b0011, HEAD_TAIL_FLIT, HEAD_TAIL_FLIT, HEAD_TAIL_FLIT, HEAD_TAIL_FLIT, 1'b1, 4'b0010, 1'b1, 1, 0);
    tbl[3]  = mk(4'b0011, HEAD_TAIL_FLIT, HEAD_TAIL_FLIT, HEAD_TAIL_FLIT, HEAD_TAIL_FLIT, 1'b1, 4'b0001, 1'b1, 2, 1);
    tbl[4]  = mk(4'b0011, HEAD_TAIL_FLIT, HEAD_TAIL_FLIT, HEAD_TAIL_FLIT, HEAD_TAIL_FLIT, 1'b1, 4'b0010, 1'b1, 3, 0);
    tbl[5]  = mk(4'b1000, HEAD_TAIL_FLIT, HEAD_TAIL_FLIT, HEAD_TAIL_FLIT, HEAD_TAIL_FLIT, 1'b1, 4'b1000, 1'b1, 4, 1);
    tbl[6]  = mk(4'b1010, HEAD_TAIL_FLIT, HEAD_FLIT,      HEAD_TAIL_FLIT, HEAD_FLIT,      1'b1, 4'b0010, 1'b1, 5, 3);
    tbl[7]  = mk(4'b1010, HEAD_TAIL_FLIT, BODY_FLIT,      HEAD_TAIL_FLIT, HEAD_FLIT,      1'b1, 4'b0010, 1'b1, 6, 1);
    tbl[8]  = mk(4'b1010, HEAD_TAIL_FLIT, BODY_FLIT,      HEAD_TAIL_FLIT, HEAD_FLIT,      1'b1, 4'b0010, 1'b1, 7, 1);
    tbl[9]  = mk(4'b1010, HEAD_TAIL_FLIT, TAIL_FLIT,      HEAD_TAIL_FLIT, HEAD_FLIT,      1'b1, 4'b0010, 1'b1, 8, 1);
    tbl[10] = mk(4'b1000, HEAD_TAIL_FLIT, HEAD_TAIL_FLIT, HEAD_TAIL_FLIT, HEAD_FLIT,      1'b1, 4'b1000, 1'b1, 9, 1);
    tbl[11] = mk(4'b1000, HEAD_TAIL_FLIT, HEAD_TAIL_FLIT, HEAD_TAIL_FLIT, BODY_FLIT,      1'b1, 4'b1000, 1'b1, 10, 3);
    for (int k = 12; k <= 16; k++) begin
      tbl[k] = mk(4'b1000, HEAD_TAIL_FLIT, HEAD_TAIL_FLIT, HEAD_TAIL_FLIT, BODY_FLIT,     1'b0, 4'b0000, 1'b1, 11, 3);
    end
    tbl[17] = mk(4'b1000, HEAD_TAIL_FLIT, HEAD_TAIL_FLIT, HEAD_TAIL_FLIT, TAIL_FLIT,      1'b1, 4'b1000, 1'b1, 11, 3);
    tbl[18] = mk(4'b0000, HEAD_TAIL_FLIT, HEAD_TAIL_FLIT, HEAD_TAIL_FLIT, HEAD_TAIL_FLIT, 1'b1, 4'b0000, 1'b1, 17, 3);
    tbl[19] = mk(4'b0001, HEAD_TAIL_FLIT, HEAD_TAIL_FLIT, HEAD_TAIL_FLIT, HEAD_TAIL_FLIT, 1'b0, 4'b0001, 1'b0, 0, 0);
    tbl[20] = mk(4'b0000, HEAD_TAIL_FLIT, HEAD_TAIL_FLIT, HEAD_TAIL_FLIT, HEAD_TAIL_FLIT, 1'b0, 4'b0000, 1'b1, 19, 0);
    tbl[21] = mk(4'b0000, HEAD_TAIL_FLIT, HEAD_TAIL_FLIT, HEAD_TAIL_FLIT, HEAD_TAIL_FLIT, 1'b1, 4'b0000, 1'b1, 19, 0);
    tbl[22] = mk(4'b0000, HEAD_TAIL_FLIT, HEAD_TAIL_FLIT, HEAD_TAIL_FLIT, HEAD_TAIL_FLIT, 1'b1, 4'b0000, 1'b0, 0, 0);

    do_reset();

    for (int k = 0; k < NumRows; k++) begin
      for (int i = 0; i < N; i++) set_in(i, tbl[k].vld[i], tbl[k].typ[i], pl(k, i));
      fout_resp.ready = tbl[k].ds;
      @(negedge clk);
      check($sformatf("tbl%0d_ready", k), 64'(dut_ready()), 64'(tbl[k].rdy));
      check($sformatf("tbl%0d_valid", k), 64'(fout_req.valid), 64'(tbl[k].ov));
      if (tbl[k].ov) begin
        ef.ftype   = tbl[tbl[k].orow].typ[tbl[k].osrc];
        ef.payload = pl(tbl[k].orow, tbl[k].osrc);
        check($sformatf("tbl%0d_fdata", k), 64'(fout_req.fdata), 64'(ef));
      end
      @(posedge clk);
      #1;
    end

    // Stray BODY in IDLE is never granted.
    do_reset();
    set_in(0, 1'b1, BODY_FLIT, 32'hB0D1_0000);
    fout_resp.ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("idle_body_ready", 64'(dut_ready()), 64'(0));
      check("idle_body_valid", 64'(fout_req.valid), 64'(0));
    end

    // Reset in the middle of a packet drops the lock and the output flit.
    do_reset();
    set_in(2, 1'b1, HEAD_FLIT, 32'h2222_0001);
    fout_resp.ready = 1'b1;
    @(negedge clk);
    check("mid_head_ready", 64'(dut_ready()), 64'(4'b0100));
    @(posedge clk);
    #1;
    set_in(2, 1'b1, BODY_FLIT, 32'h2222_0002);
    check("mid_out_valid", 64'(fout_req.valid), 64'(1));
    arst = 1'b1;
    #1;
    check("mid_rst_valid", 64'(fout_req.valid), 64'(0));
    check("mid_rst_fdata", 64'(fout_req.fdata), 64'(0));
    check("mid_rst_ready", 64'(dut_ready()), 64'(0));
    #1;
    arst = 1'b0;
    set_in(0, 1'b1, HEAD_FLIT, 32'h0000_0A0A);
    @(negedge clk);
    check("post_rst_ready", 64'(dut_ready()), 64'(4'b0001));
    @(posedge clk);
    #1;
    ef.ftype   = HEAD_FLIT;
    ef.payload = 32'h0000_0A0A;
    check("post_rst_valid", 64'(fout_req.valid), 64'(1));
    check("post_rst_fdata", 64'(fout_req.fdata), 64'(ef));

    // Randomized traffic against the model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        set_in(i, ($urandom_range(0, 9) < 7), flit_type_t'($urandom_range(0, 3)), $urandom);
      end
      fout_resp.ready = ($urandom_range(0, 9) < 7);
      @(negedge clk);
      r = m_ready();
      check("rnd_ready", 64'(dut_ready()), 64'(r));
      check("rnd_valid", 64'(fout_req.valid), 64'(m_q.size() != 0));
      if (m_q.size() != 0 && fout_req.valid) begin
        check("rnd_fdata", 64'(fout_req.fdata), 64'(m_q[0]));
      end
      m_commit(r);
      @(posedge clk);
      #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
